// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN core types, defaults and elaboration helpers
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } win_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sum_3regs.sv
// rtl/sum_3regs.sv - combinational unsigned three-operand row adder
module sum_3regs #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_c,
  output logic [DATA_WIDTH+1:0] sum
);

  assign sum = {2'b00, in_a} + {2'b00, in_b} + {2'b00, in_c};

endmodule

// File: rtl/window_sum_ctrl.sv
// rtl/window_sum_ctrl.sv - accumulates ROWS row sums into one window total
module window_sum_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ROWS       = 3,
  parameter int ACC_WIDTH  = DATA_WIDTH + 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_p0,
  input  logic [DATA_WIDTH-1:0] in_p1,
  input  logic [DATA_WIDTH-1:0] in_p2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  win_count
);

  localparam int RC_WIDTH = 4;
  localparam logic [RC_WIDTH-1:0] LAST_ROW = RC_WIDTH'(ROWS - 1);

  if (ACC_WIDTH < DATA_WIDTH + 2 + clog2(ROWS)) begin : g_acc_width_check
    $error("ACC_WIDTH too narrow for DATA_WIDTH and ROWS");
  end
  if (ROWS < 2 || ROWS > 15) begin : g_rows_check
    $error("ROWS must be within 2..15");
  end

  win_state_t            state_q, state_d;
  logic [RC_WIDTH-1:0]   row_cnt_q, row_cnt_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  out_sum_q, out_sum_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  win_count_q, win_count_d;
  logic [DATA_WIDTH+1:0] row_sum;
  logic [ACC_WIDTH-1:0]  row_sum_ext;
  logic                  accept;

  sum_3regs #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_row_adder (
    .in_a(in_p0),
    .in_b(in_p1),
    .in_c(in_p2),
    .sum (row_sum)
  );

  assign row_sum_ext = ACC_WIDTH'(row_sum);
  assign in_ready    = !clear && (state_q == ACCUM || out_ready);
  assign accept      = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    win_count_d = win_count_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d     = '0;
          row_cnt_d = '0;
        end else if (accept) begin
          if (row_cnt_q == LAST_ROW) begin
            out_sum_d   = acc_q + row_sum_ext;
            out_valid_d = 1'b1;
            acc_d       = '0;
            row_cnt_d   = '0;
            state_d     = OUT;
          end else begin
            acc_d     = acc_q + row_sum_ext;
            row_cnt_d = row_cnt_q + RC_WIDTH'(1);
          end
        end
      end
      OUT: begin
        // Handoff cycle may also take row 0 of the next window.
        if (out_ready) begin
          out_valid_d = 1'b0;
          win_count_d = win_count_q + CNT_WIDTH'(1);
          state_d     = ACCUM;
          if (accept) begin
            acc_d     = row_sum_ext;
            row_cnt_d = RC_WIDTH'(1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      row_cnt_q   <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      win_count_q <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      win_count_q <= win_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign busy      = (row_cnt_q != '0);
  assign win_count = win_count_q;

endmodule

// File: tb/tb_window_sum_ctrl.sv
// tb/tb_window_sum_ctrl.sv - directed self-checking bench for window_sum_ctrl
module tb_window_sum_ctrl;

  localparam int DW = 16;
  localparam int AW = DW + 6;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_p0, in_p1, in_p2;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          busy;
  logic [CW-1:0] win_count;

  int checks;
  int errors;

  window_sum_ctrl #(
    .DATA_WIDTH(DW),
    .ROWS      (3),
    .ACC_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_p0    (in_p0),
    .in_p1    (in_p1),
    .in_p2    (in_p2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy),
    .win_count(win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    in_valid = 1'b1;
    in_p0    = a;
    in_p1    = b;
    in_p2    = c;
    tick();
  endtask

  task automatic idle_tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_p0     = '0;
    in_p1     = '0;
    in_p2     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_win_count", 32'(win_count), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic window 1..9
    beat(1, 2, 3);
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_no_valid_early", {31'd0, out_valid}, 32'd0);
    beat(4, 5, 6);
    check("basic_no_valid_row2", {31'd0, out_valid}, 32'd0);
    beat(7, 8, 9);
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_sum", 32'(out_sum), 32'd45);
    idle_tick();
    check("basic_drop_valid", {31'd0, out_valid}, 32'd0);
    check("basic_win_count", 32'(win_count), 32'd1);

    // Max-value products
    beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
    beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
    beat(16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("max_valid", {31'd0, out_valid}, 32'd1);
    check("max_sum", 32'(out_sum), 32'd589815);
    idle_tick();
    check("max_win_count", 32'(win_count), 32'd2);

    // Backpressure, then handoff with a same-cycle beat
    out_ready = 1'b0;
    beat(2, 2, 2);
    beat(2, 2, 2);
    beat(2, 2, 2);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    in_p0    = 10;
    in_p1    = 10;
    in_p2    = 10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold_sum_%0d", i), 32'(out_sum), 32'd18);
      check($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_handoff_valid", {31'd0, out_valid}, 32'd0);
    check("bp_win_count", 32'(win_count), 32'd3);
    check("bp_busy_row0", {31'd0, busy}, 32'd1);
    beat(1, 0, 0);
    beat(0, 0, 2);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_sum", 32'(out_sum), 32'd33);
    idle_tick();
    check("bp_next_win_count", 32'(win_count), 32'd4);

    // Back-to-back: 4 windows of rows (k,k,k) -> 9k each
    for (int i = 0; i < 12; i++) begin
      int v;
      v = i / 3 + 1;
      beat(DW'(v), DW'(v), DW'(v));
      if (i % 3 == 2) begin
        check($sformatf("b2b_valid_%0d", i), {31'd0, out_valid}, 32'd1);
        check($sformatf("b2b_sum_%0d", i), 32'(out_sum), 32'(9 * v));
      end else begin
        check($sformatf("b2b_idle_%0d", i), {31'd0, out_valid}, 32'd0);
      end
    end
    idle_tick();
    check("b2b_win_count", 32'(win_count), 32'd8);

    // clear mid-window blocks the beat and drops the partial sum
    beat(5, 5, 5);
    check("clr_busy_before", {31'd0, busy}, 32'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0;
    check("clr_busy_after", {31'd0, busy}, 32'd0);
    check("clr_no_valid", {31'd0, out_valid}, 32'd0);
    beat(1, 1, 1);
    beat(1, 1, 1);
    beat(1, 1, 1);
    check("clr_next_valid", {31'd0, out_valid}, 32'd1);
    check("clr_next_sum", 32'(out_sum), 32'd9);
    idle_tick();
    check("clr_win_count", 32'(win_count), 32'd9);

    // clear in OUT leaves the pending result, then reset drops it
    out_ready = 1'b0;
    beat(3, 3, 3);
    beat(3, 3, 3);
    beat(3, 3, 3);
    check("out_clr_pre_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    check("out_clr_valid_kept", {31'd0, out_valid}, 32'd1);
    check("out_clr_sum_kept", 32'(out_sum), 32'd27);
    check("out_clr_win_count", 32'(win_count), 32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("rst_win_count_after", 32'(win_count), 32'd0);
    check("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("rst_out_sum_after", 32'(out_sum), 32'd0);
    check("rst_busy_after", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
